// File: rtl/wide_addsub_sequencer_pkg.sv
// Shared constants for the 256-bit add/sub sequencer: limb geometry and
// FSM state encodings.
package wide_addsub_sequencer_pkg;

  localparam int LIMB_W_DEF = 64;
  localparam int LIMBS_DEF  = 4;
  localparam int W_DEF      = LIMB_W_DEF * LIMBS_DEF;
  localparam int IDX_W_DEF  = $clog2(LIMBS_DEF);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic even_parity8(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/wide_addsub_sequencer_if.sv
// Issue/result bundle between the ALU issue logic and the wide add/sub path.
interface wide_addsub_sequencer_if
  import wide_addsub_sequencer_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         start;
  logic         mode;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         SF;
  logic         CF;
  logic         OF;
  logic         PF;
  logic         ZF;

  modport master (
    output start, mode, A, B,
    input  busy, done, result, SF, CF, OF, PF, ZF
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, result, SF, CF, OF, PF, ZF
  );

endinterface

// File: rtl/wide_addsub_limb.sv
// One limb of the shared adder: conditionally inverts B for subtract, adds
// with an explicit carry-in and reports the signed overflow of its MSB.
module wide_addsub_limb
  import wide_addsub_sequencer_pkg::*;
#(
  parameter int LIMB_W = LIMB_W_DEF
) (
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic [LIMB_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  logic [LIMB_W-1:0] b_eff;

  always_comb begin
    b_eff       = b ^ {LIMB_W{sub}};
    {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{LIMB_W{1'b0}}, cin};
    ovf         = (a[LIMB_W-1] == b_eff[LIMB_W-1]) && (sum[LIMB_W-1] != a[LIMB_W-1]);
  end

endmodule

// File: rtl/wide_addsub_sequencer.sv
// Multi-precision add/subtract: walks LIMBS limbs LSB-first through one shared
// LIMB_W adder, then commits the wide result and flags and pulses done.
module wide_addsub_sequencer
  import wide_addsub_sequencer_pkg::*;
#(
  parameter int LIMB_W = LIMB_W_DEF,
  parameter int LIMBS  = LIMBS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  wide_addsub_sequencer_if.slave  bus
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LIMBS - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      acc;
  logic              mode_q;
  logic              carry_q;
  logic [LIMB_W-1:0] sum;
  logic              cout;
  logic              ovf;
  logic [W-1:0]      acc_next;

  wide_addsub_limb #(.LIMB_W(LIMB_W)) u_limb (
    .a    (a_q[LIMB_W-1:0]),
    .b    (b_q[LIMB_W-1:0]),
    .cin  (carry_q),
    .sub  (mode_q),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // Operands shift down one limb per cycle and the accumulator fills from the
  // top, so after LIMBS cycles limb idx of acc holds the sum of limb idx.
  assign acc_next = {sum, acc[W-1:LIMB_W]};

  assign bus.busy = (state == ST_RUN);
  assign bus.done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      bus.result <= '0;
      bus.SF     <= 1'b0;
      bus.CF     <= 1'b0;
      bus.OF     <= 1'b0;
      bus.PF     <= 1'b0;
      bus.ZF     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            mode_q  <= bus.mode;
            carry_q <= bus.mode;
            idx     <= '0;
            state   <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> LIMB_W;
          b_q     <= b_q >> LIMB_W;
          acc     <= acc_next;
          carry_q <= cout;
          if (idx == LAST_IDX) begin
            state      <= ST_DONE;
            bus.result <= acc_next;
            bus.CF     <= cout ^ mode_q;
            bus.OF     <= ovf;
            bus.SF     <= acc_next[W-1];
            bus.ZF     <= ~|acc_next;
            bus.PF     <= even_parity8(acc_next[7:0]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_addsub_sequencer.sv
// Scoreboard bench for wide_addsub_sequencer: expected results are queued at
// issue time from a 257-bit reference model and compared when done pulses.
module tb_wide_addsub_sequencer;
  import wide_addsub_sequencer_pkg::*;

  localparam int W = W_DEF;

  typedef struct {
    logic [W-1:0] r;
    logic         sf, cf, of, pf, zf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  wide_addsub_sequencer_if #(.W(W)) bus ();

  wide_addsub_sequencer #(.LIMB_W(LIMB_W_DEF), .LIMBS(LIMBS_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t       e;
    logic [W:0] full;
    if (!m) begin
      full = {1'b0, a} + {1'b0, b};
      e.cf = full[W];
      e.r  = full[W-1:0];
      e.of = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    end else begin
      e.r  = a - b;
      e.cf = (a < b);
      e.of = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    end
    e.sf = e.r[W-1];
    e.zf = (e.r == '0);
    e.pf = ($countones(e.r[7:0]) % 2) == 0;
    return e;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int unsigned i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.result, e.r);
        check("SF", bus.SF, e.sf);
        check("CF", bus.CF, e.cf);
        check("OF", bus.OF, e.of);
        check("PF", bus.PF, e.pf);
        check("ZF", bus.ZF, e.zf);
      end
    end
  end

  // Caller is at a negedge; returns at the negedge of the DONE cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int cyc;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.mode  = m;
    sb.push_back(model(a, b, m));
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = rand_wide();
    bus.B     = rand_wide();
    bus.mode  = ~m;
    check("busy_after_start", bus.busy, 1);
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, LIMBS_DEF + 1);
  endtask

  logic [W-1:0] one_w, max_w, smax_w, smin_w, l0_max;
  int           d0;

  initial begin
    one_w  = 1;
    max_w  = '1;
    smax_w = {1'b0, {(W-1){1'b1}}};
    smin_w = {1'b1, {(W-1){1'b0}}};
    l0_max = {{(W-64){1'b0}}, {64{1'b1}}};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl_flags", {bus.busy, bus.done, bus.SF, bus.CF, bus.OF, bus.PF, bus.ZF}, 0);
    check("reset_result", bus.result, 0);
    rst = 1'b0;
    @(negedge clk);

    issue(l0_max, one_w, 1'b0);
    check("ripple_result_2p64", bus.result, one_w << 64);
    @(negedge clk);
    issue(max_w, one_w, 1'b0);
    @(negedge clk);
    issue('0, one_w, 1'b1);
    check("borrow_result_all_ones", bus.result, max_w);
    @(negedge clk);
    issue(smax_w, one_w, 1'b0);
    check("sovf_add_OF", bus.OF, 1);
    @(negedge clk);
    issue(smin_w, one_w, 1'b1);
    check("sovf_sub_OF", bus.OF, 1);

    // start held through the busy window, dropped in the DONE cycle
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.A = 256'd1000;
    bus.B = 256'd24;
    bus.mode = 1'b0;
    sb.push_back(model(256'd1000, 256'd24, 1'b0));
    repeat (LIMBS_DEF + 1) @(negedge clk);
    check("held_start_done_now", bus.done, 1);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_start_once", done_cnt - d0, 1);

    // back-to-back: second start issued in the DONE cycle
    issue(rand_wide(), rand_wide(), 1'b0);
    issue(256'd5, 256'd3, 1'b1);
    check("b2b_result", bus.result, 2);
    check("b2b_PF", bus.PF, 0);

    // reset in the middle of a run
    @(negedge clk);
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.A = max_w;
    bus.B = max_w;
    bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ctrl_flags", {bus.busy, bus.done, bus.SF, bus.CF, bus.OF, bus.PF, bus.ZF}, 0);
    check("midrst_result", bus.result, 0);
    repeat (8) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    issue(256'd77, 256'd77, 1'b1);

    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(rand_wide(), (i % 3 == 0) ? ~l0_max : rand_wide(), i[0]);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
